// File: rtl/ew_pkg.sv
// Shared types and constants for the E/W sensor-pattern generator.
// Patterns are expressed as {lead line, trail line}; the top maps them onto E/W by direction.
package ew_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        BOTH  = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } ew_state_t;

    localparam logic DIR_EAST = 1'b0;
    localparam logic DIR_WEST = 1'b1;

    localparam logic [1:0] PAT_IDLE  = 2'b00;
    localparam logic [1:0] PAT_LEAD  = 2'b10;
    localparam logic [1:0] PAT_BOTH  = 2'b11;
    localparam logic [1:0] PAT_TRAIL = 2'b01;
    localparam logic [1:0] PAT_GAP   = 2'b00;

    function automatic logic [1:0] phase_pattern(input ew_state_t s);
        logic [1:0] p;
        case (s)
            LEAD:    p = PAT_LEAD;
            BOTH:    p = PAT_BOTH;
            TRAIL:   p = PAT_TRAIL;
            GAP:     p = PAT_GAP;
            default: p = PAT_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ew_dwell_timer.sv
// Loadable down-counter that times one phase; expired is high while the count reads zero.
module ew_dwell_timer
    import ew_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] value,
    output logic               expired
);

    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/ew_pass_gen.sv
// E/W sensor-pattern generator: emits count passes of lead/both/trail/gap, each phase dwell+1 cycles.
// Optional abort input is enabled by defining EW_GEN_ABORT_EN.
module ew_pass_gen
    import ew_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [COUNT_W-1:0] count,
`ifdef EW_GEN_ABORT_EN
    input  logic               abort,
`endif
    output logic               E,
    output logic               W,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] passes_done
);

    ew_state_t          state;
    ew_state_t          nxt;
    logic               dir_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] pd_plus1;
    logic               accept;
    logic               load;
    logic               done_set;
    logic               pass_inc;
    logic               expired;
    logic               dir_sel;
    logic [DWELL_W-1:0] timer_value;
    logic [1:0]         pat;

    // In IDLE the command inputs are used directly so the first phase starts on the accepting edge.
    assign dir_sel     = (state == IDLE) ? dir   : dir_q;
    assign timer_value = (state == IDLE) ? dwell : dwell_q;
    assign pd_plus1    = passes_done + 1'b1;
    assign pat         = phase_pattern(nxt);

    ew_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .value   (timer_value),
        .expired (expired)
    );

    always_comb begin
        nxt      = state;
        accept   = 1'b0;
        load     = 1'b0;
        done_set = 1'b0;
        pass_inc = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (count == '0) begin
                        done_set = 1'b1;
                    end else begin
                        nxt  = LEAD;
                        load = 1'b1;
                    end
                end
            end
            LEAD: begin
                if (expired) begin
                    nxt  = BOTH;
                    load = 1'b1;
                end
            end
            BOTH: begin
                if (expired) begin
                    nxt  = TRAIL;
                    load = 1'b1;
                end
            end
            TRAIL: begin
                if (expired) begin
                    nxt  = GAP;
                    load = 1'b1;
                end
            end
            GAP: begin
                if (expired) begin
                    pass_inc = 1'b1;
                    if (pd_plus1 == count_q) begin
                        nxt      = IDLE;
                        done_set = 1'b1;
                    end else begin
                        nxt  = LEAD;
                        load = 1'b1;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
`ifdef EW_GEN_ABORT_EN
        // Abort beats an expiring phase; the pass in flight is not counted.
        if (abort && state != IDLE) begin
            nxt      = IDLE;
            load     = 1'b0;
            done_set = 1'b0;
            pass_inc = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            E           <= 1'b0;
            W           <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            passes_done <= '0;
            dir_q       <= DIR_EAST;
            dwell_q     <= '0;
            count_q     <= '0;
        end else begin
            state <= nxt;
            busy  <= (nxt != IDLE);
            done  <= done_set;
            if (dir_sel == DIR_EAST) begin
                W <= pat[1];
                E <= pat[0];
            end else begin
                E <= pat[1];
                W <= pat[0];
            end
            if (accept) begin
                dir_q       <= dir;
                dwell_q     <= dwell;
                count_q     <= count;
                passes_done <= '0;
            end else if (pass_inc) begin
                passes_done <= pd_plus1;
            end
        end
    end

endmodule

// File: tb/tb_ew_pass_gen.sv
// Scoreboard bench for ew_pass_gen: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
// Define EW_GEN_ABORT_EN to also exercise the abort input.
module tb_ew_pass_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [3:0] count = 4'd0;
    logic       abort = 1'b0;
    logic       E, W, busy, done;
    logic [3:0] passes_done;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       e;
        logic       w;
        logic       busy;
        logic       done;
        logic [3:0] pd;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    ew_pass_gen #(.DWELL_W(8), .COUNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dir         (dir),
        .dwell       (dwell),
        .count       (count),
`ifdef EW_GEN_ABORT_EN
        .abort       (abort),
`endif
        .E           (E),
        .W           (W),
        .busy        (busy),
        .done        (done),
        .passes_done (passes_done)
    );

    task automatic checkOutput(input string tag, input exp_t x);
        logic [7:0] act, req;
        act = {E, W, busy, done, passes_done};
        req = {x.e, x.w, x.busy, x.done, x.pd};
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got E=%b W=%b busy=%b done=%b pd=%0d, want E=%b W=%b busy=%b done=%b pd=%0d at %0t",
                     tag, E, W, busy, done, passes_done, x.e, x.w, x.busy, x.done, x.pd, $time);
        end
    endtask

    // Reference pass sequence: cycles counted from 1 after the accepting edge.
    task automatic pushModel(input logic d, input int dw, input int c, input int abort_at, input int tail);
        int idx;
        int plen;
        int fin;
        logic ld, tr;
        exp_t x;
        idx  = 1;
        plen = 4 * (dw + 1);
        if (c == 0) begin
            x = '{e: 1'b0, w: 1'b0, busy: 1'b0, done: 1'b1, pd: 4'd0};
            exp_q.push_back(x);
            fin = 0;
        end else begin
            for (int p = 0; p < c; p++) begin
                for (int ph = 0; ph < 4; ph++) begin
                    ld = (ph == 0 || ph == 1);
                    tr = (ph == 1 || ph == 2);
                    for (int k = 0; k <= dw; k++) begin
                        if (abort_at == 0 || idx <= abort_at) begin
                            x.busy = 1'b1;
                            x.done = 1'b0;
                            x.pd   = 4'(p);
                            x.w    = (d == 1'b0) ? ld : tr;
                            x.e    = (d == 1'b0) ? tr : ld;
                            exp_q.push_back(x);
                        end
                        idx++;
                    end
                end
            end
            if (abort_at == 0) begin
                x = '{e: 1'b0, w: 1'b0, busy: 1'b0, done: 1'b1, pd: 4'(c)};
                exp_q.push_back(x);
                fin = c;
            end else begin
                fin = (abort_at - 1) / plen;
            end
        end
        for (int t = 0; t < tail; t++) begin
            x = '{e: 1'b0, w: 1'b0, busy: 1'b0, done: 1'b0, pd: 4'(fin)};
            exp_q.push_back(x);
        end
    endtask

    // Called just after a negedge; drives a one-cycle start and scrambles inputs afterwards.
    task automatic applyStimulus(input logic d, input int dw, input int c,
                                 input bit push, input int abort_at, input int tail);
        start = 1'b1;
        dir   = d;
        dwell = 8'(dw);
        count = 4'(c);
        if (push) pushModel(d, dw, c, abort_at, tail);
        @(negedge clk);
        #1;
        start = 1'b0;
        dir   = ~d;
        dwell = 8'($urandom_range(0, 255));
        count = 4'($urandom_range(0, 15));
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d expected samples left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compare every cycle an expectation is pending; otherwise done must stay low.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0) begin
                checkOutput("scoreboard", exp_q.pop_front());
            end else begin
                total++;
                if (done !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_done: got done=%b, want 0 at %0t", done, $time);
                end
            end
        end
    end

    initial begin
        exp_t z;
        z = '{e: 1'b0, w: 1'b0, busy: 1'b0, done: 1'b0, pd: 4'd0};

        #12;
        checkOutput("reset_hold", z);
        @(negedge clk);
        #1;
        rst = 1'b0;
        waitNeg(2);
        checkOutput("after_reset", z);

        $display("[TB] eastbound dwell=2 count=1");
        applyStimulus(1'b0, 2, 1, 1'b1, 0, 2);
        waitDrain();

        $display("[TB] reset during second-pass BOTH");
        applyStimulus(1'b1, 3, 2, 1'b0, 0, 0);
        waitNeg(21);
        checkOutput("pre_reset_both", '{e: 1'b1, w: 1'b1, busy: 1'b1, done: 1'b0, pd: 4'd1});
        rst = 1'b1;
        #1;
        checkOutput("async_reset", z);
        waitNeg(2);
        rst = 1'b0;
        waitNeg(6);
        checkOutput("post_reset_idle", z);

        $display("[TB] westbound dwell=0 count=3, ignored start, back-to-back");
        applyStimulus(1'b1, 0, 3, 1'b1, 0, 0);
        waitNeg(3);
        start = 1'b1;
        count = 4'd0;
        waitNeg(1);
        start = 1'b0;
        waitNeg(8);
        applyStimulus(1'b0, 5, 0, 1'b1, 0, 0);
        applyStimulus(1'b0, 1, 2, 1'b1, 0, 3);
        waitDrain();

`ifdef EW_GEN_ABORT_EN
        $display("[TB] abort in second-pass TRAIL");
        applyStimulus(1'b0, 3, 2, 1'b1, 26, 3);
        waitNeg(25);
        abort = 1'b1;
        waitNeg(1);
        abort = 1'b0;
        waitDrain();
        $display("[TB] abort in IDLE is ignored, start wins over abort");
        abort = 1'b1;
        waitNeg(2);
        applyStimulus(1'b1, 0, 1, 1'b1, 0, 2);
        abort = 1'b0;
        waitDrain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
